nt_cone_pipe: RTL and testbench
===============================

Name: nt_cone_pipe

Overview:
- Parametrised successor to the single-bit Nt-node subcircuits in the trojan-detection benchmark set.
- Implements the same registered NOR/NAND/OR logic cone, but bit-sliced across WIDTH lanes.
- Adds a configurable output pipeline, valid tracking, and a rare-pattern hit monitor with a sticky alarm.
- Sits between generated benchmark netlists and the detection harness as a golden, scalable reference node.

Parameters:
- WIDTH, 4, number of independent bit lanes in every data port.
- PIPE_DEPTH, 2, number of result register stages (≥1); stage 1 is the result register, the rest are pure delay.
- CNT_W, 8, width of the hit counter.
- TRIG_THRESH, 3, hit count at which the alarm asserts (1..2^CNT_W-1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- a  in  WIDTH  cone input, registered in the input stage.
- b  in  WIDTH  cone input, registered in the input stage.
- e  in  WIDTH  cone input, registered in the input stage.
- c  in  WIDTH  cone input, combinational into the result stage (see the optional feature).
- d  in  WIDTH  cone input, combinational into the result stage (see the optional feature).
- in_valid  in  1  marks the a/b/e sample of this cycle as valid.
- clr  in  1  synchronous clear of hit_cnt and alarm.
- out  out  WIDTH  cone result after the pipeline.
- out_valid  out  1  in_valid delayed to align with out.
- hit_cnt  out  CNT_W  saturating count of monitor hits.
- alarm  out  1  sticky trigger flag.

Behaviour:
- Reset (rst=0, async) clears every flop: input regs a1/b1/e1/v1, all pipe stages, out, out_valid, hit_cnt and alarm all go to 0. Outputs hold 0 until the first clock edge after release.
- Input stage: a1, b1, e1 and v1 load a, b, e and in_valid on every edge. There is no enable and no stall.
- Per lane i, the result is f[i] = ~((c[i]&d[i]) | e1[i]) & ~(a1[i] & (b1[i] | e1[i])).
- Result stage 1 loads f; stages 2..PIPE_DEPTH shift it through. out is the last stage.
- The valid pipe runs alongside the data: out_valid follows in_valid with the same latency as a/b/e.
- Latency from a/b/e/in_valid to out/out_valid is 1+PIPE_DEPTH cycles.
- Latency from c/d to out is PIPE_DEPTH cycles (macro off).
- A sample with in_valid=0 still propagates data; only out_valid marks it invalid.
- Monitor: hit = out_valid & (out == all-ones), evaluated on registered outputs. Each edge with hit increments hit_cnt.
- hit_cnt saturates at 2^CNT_W-1; no wrap.
- alarm sets on the edge where the next value of hit_cnt ≥ TRIG_THRESH. It stays at 1 until reset or clr.
- clr=1 forces hit_cnt←0 and alarm←0 on that edge and takes priority over a simultaneous hit, i.e. that hit is not counted.
- Reset mid-pipeline discards all in-flight samples. No sample emerges with out_valid=1 until in_valid has been high again for the full latency.

Optional Feature:
- Macro: NT_ALIGN_EN.
- Defined: c and d are also registered in the input stage (c1, d1, reset 0), and f uses c1&d1. All inputs then share a latency of 1+PIPE_DEPTH, and the bench compares against a uniformly delayed model.
- Undefined: c and d feed f combinationally, as above. Latencies are PIPE_DEPTH for c/d and 1+PIPE_DEPTH for a/b/e.

Test Plan (WIDTH=4, PIPE_DEPTH=2, CNT_W=8, TRIG_THRESH=3, macro off):
- Reset: hold rst=0 with random inputs toggling, then release → out=0000, out_valid=0, hit_cnt=0, alarm=0 until the first sample arrives 3 edges later.
- Latency: a=F, b=0, e=0, in_valid=1 for one cycle, c=d=0 held → out=1111 with out_valid=1 exactly 3 edges later, for one cycle.
- Lane logic: (a,b,e,c,d) = (F,F,0,0,0) → out=0000; (0,0,F,0,0) → out=0000; (0,0,0,F,F) → out=0000; (0,0,0,F,0) → out=1111; mixed a=5, b=5, rest 0 → out=A.
- Trigger: three valid all-ones samples, non-consecutive → hit_cnt 1,2,3, and alarm rises on the third hit edge. A fourth sample with in_valid=0 leaves hit_cnt=3.
- Clear vs hit: clr=1 on the same edge as a hit → hit_cnt=0, alarm=0. The next hit → hit_cnt=1.
- Saturation and reset: with CNT_W=2, drive 5 hits → hit_cnt stops at 3. Assert rst mid-stream → all outputs 0 immediately (asynchronous), and in-flight samples are lost.

Source files
------------

// File: rtl/nt_cone_pipe_if.sv
// Bus bundle for nt_cone_pipe: cone inputs, sample valid, monitor clear and all results.
// The stimulus side uses the master modport; the cone node uses the slave modport.
interface nt_cone_pipe_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] e;
   logic [WIDTH-1:0] c;
   logic [WIDTH-1:0] d;
   logic             in_valid;
   logic             clr;
   logic [WIDTH-1:0] out;
   logic             out_valid;
   logic [CNT_W-1:0] hit_cnt;
   logic             alarm;

   modport master (
      output a, b, e, c, d, in_valid, clr,
      input  out, out_valid, hit_cnt, alarm
   );

   modport slave (
      input  a, b, e, c, d, in_valid, clr,
      output out, out_valid, hit_cnt, alarm
   );
endinterface

// File: rtl/nt_cone_pipe.sv
// Bit-sliced registered NOR/NAND/OR cone with output pipeline, valid tracking and a
// saturating rare-pattern hit monitor with sticky alarm. Define NT_ALIGN_EN to also register c/d.
module nt_cone_pipe #(
   parameter int WIDTH       = 4,
   parameter int PIPE_DEPTH  = 2,
   parameter int CNT_W       = 8,
   parameter int TRIG_THRESH = 3
) (
   input logic           clk,
   input logic           rst,
   nt_cone_pipe_if.slave bus
);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] THRESH  = CNT_W'(TRIG_THRESH);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [WIDTH-1:0] a1_q;
   logic [WIDTH-1:0] b1_q;
   logic [WIDTH-1:0] e1_q;
   logic             v1_q;
   logic [WIDTH-1:0] pipe_q [PIPE_DEPTH];
   logic [PIPE_DEPTH-1:0] vpipe_q;
   logic [WIDTH-1:0] cd_s;
   logic [WIDTH-1:0] f_s;
   logic             hit_s;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             alarm_q;
   logic             alarm_d;

   // Input stage: a/b/e/in_valid sampled every edge, no enable.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a1_q <= {WIDTH{1'b0}};
         b1_q <= {WIDTH{1'b0}};
         e1_q <= {WIDTH{1'b0}};
         v1_q <= 1'b0;
      end else begin
         a1_q <= bus.a;
         b1_q <= bus.b;
         e1_q <= bus.e;
         v1_q <= bus.in_valid;
      end
   end

`ifdef NT_ALIGN_EN
   logic [WIDTH-1:0] c1_q;
   logic [WIDTH-1:0] d1_q;

   // Aligned build: c/d share the input-stage latency of a/b/e.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         c1_q <= {WIDTH{1'b0}};
         d1_q <= {WIDTH{1'b0}};
      end else begin
         c1_q <= bus.c;
         d1_q <= bus.d;
      end
   end

   assign cd_s = c1_q & d1_q;
`else
   assign cd_s = bus.c & bus.d;
`endif

   assign f_s = ~(cd_s | e1_q) & ~(a1_q & (b1_q | e1_q));

   // Result register followed by pure delay stages; valid travels alongside.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < PIPE_DEPTH; k++) begin
            pipe_q[k] <= {WIDTH{1'b0}};
         end
         vpipe_q <= {PIPE_DEPTH{1'b0}};
      end else begin
         pipe_q[0]  <= f_s;
         vpipe_q[0] <= v1_q;
         for (int k = 1; k < PIPE_DEPTH; k++) begin
            pipe_q[k]  <= pipe_q[k-1];
            vpipe_q[k] <= vpipe_q[k-1];
         end
      end
   end

   // Monitor looks only at registered outputs, so hits lag out by one edge.
   assign hit_s = vpipe_q[PIPE_DEPTH-1] & (&pipe_q[PIPE_DEPTH-1]);

   // Next-state for the hit counter and alarm; clr beats a coincident hit.
   always_comb begin
      cnt_d   = cnt_q;
      alarm_d = alarm_q;
      if (bus.clr) begin
         cnt_d   = {CNT_W{1'b0}};
         alarm_d = 1'b0;
      end else begin
         if (hit_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
         end else begin
            cnt_d = cnt_q;
         end
         alarm_d = alarm_q | (cnt_d >= THRESH);
      end
   end

   // Monitor state registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q   <= {CNT_W{1'b0}};
         alarm_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         alarm_q <= alarm_d;
      end
   end

   assign bus.out       = pipe_q[PIPE_DEPTH-1];
   assign bus.out_valid = vpipe_q[PIPE_DEPTH-1];
   assign bus.hit_cnt   = cnt_q;
   assign bus.alarm     = alarm_q;
endmodule

// File: tb/tb_nt_cone_pipe.sv
// Directed bench for nt_cone_pipe (WIDTH=4, PIPE_DEPTH=2): a CNT_W=8 instance plus a
// CNT_W=2 instance sharing the same stimulus to exercise counter saturation.
module tb_nt_cone_pipe;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   nt_cone_pipe_if #(.WIDTH(4), .CNT_W(8)) bus ();
   nt_cone_pipe_if #(.WIDTH(4), .CNT_W(2)) bus2 ();

   assign bus2.a        = bus.a;
   assign bus2.b        = bus.b;
   assign bus2.e        = bus.e;
   assign bus2.c        = bus.c;
   assign bus2.d        = bus.d;
   assign bus2.in_valid = bus.in_valid;
   assign bus2.clr      = bus.clr;

   nt_cone_pipe #(.WIDTH(4), .PIPE_DEPTH(2), .CNT_W(8), .TRIG_THRESH(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   nt_cone_pipe #(.WIDTH(4), .PIPE_DEPTH(2), .CNT_W(2), .TRIG_THRESH(3)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] e,
                        input logic [3:0] c, input logic [3:0] d, input logic v);
      bus.a        = a;
      bus.b        = b;
      bus.e        = e;
      bus.c        = c;
      bus.d        = d;
      bus.in_valid = v;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Idle vector (a=b=F) makes f=0, so idle cycles never look like hits.
   task automatic idle();
      drive(4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0);
   endtask

   task automatic pulse_clr();
      bus.clr = 1'b1;
      tick();
      bus.clr = 1'b0;
   endtask

   task automatic test_reset();
      rst     = 1'b0;
      bus.clr = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)),
               4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));
         tick();
         checks++;
         if ({bus.out, bus.out_valid, bus.hit_cnt, bus.alarm} !== 14'h0) begin
            errors++;
            $display("FAIL reset_hold: got out=%h v=%b cnt=%0d alarm=%b expected all 0",
                     bus.out, bus.out_valid, bus.hit_cnt, bus.alarm);
         end
      end
      drive(4'hF, 4'hF, 4'h0, 4'hF, 4'hF, 1'b0);
      rst = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         checks++;
         if ({bus.out, bus.out_valid, bus.hit_cnt, bus.alarm} !== 14'h0) begin
            errors++;
            $display("FAIL reset_release edge%0d: got out=%h v=%b cnt=%0d alarm=%b expected all 0",
                     i, bus.out, bus.out_valid, bus.hit_cnt, bus.alarm);
         end
      end
   endtask

   task automatic test_latency();
      logic [3:0] exp_out [4];
      logic       exp_v   [4];
      exp_out = '{4'h0, 4'h0, 4'hF, 4'h0};
      exp_v   = '{1'b0, 1'b0, 1'b1, 1'b0};
      idle();
      tick(); tick(); tick();
      drive(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 0) idle();
         checks++;
         if ({bus.out, bus.out_valid} !== {exp_out[i], exp_v[i]}) begin
            errors++;
            $display("FAIL latency edge%0d: got out=%h v=%b expected out=%h v=%b",
                     i + 1, bus.out, bus.out_valid, exp_out[i], exp_v[i]);
         end
      end
      checks++;
      if (bus.hit_cnt !== 8'd1) begin
         errors++;
         $display("FAIL latency_hit: got cnt=%0d expected 1", bus.hit_cnt);
      end
      pulse_clr();
      checks++;
      if (bus.hit_cnt !== 8'd0) begin
         errors++;
         $display("FAIL latency_clr: got cnt=%0d expected 0", bus.hit_cnt);
      end
   endtask

   task automatic test_lane_logic();
      logic [3:0] va [5];
      logic [3:0] vb [5];
      logic [3:0] ve [5];
      logic [3:0] vc [5];
      logic [3:0] vd [5];
      logic [3:0] vexp [5];
      va   = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h5};
      vb   = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h5};
      ve   = '{4'h0, 4'hF, 4'h0, 4'h0, 4'h0};
      vc   = '{4'h0, 4'h0, 4'hF, 4'hF, 4'h0};
      vd   = '{4'h0, 4'h0, 4'hF, 4'h0, 4'h0};
      vexp = '{4'h0, 4'h0, 4'h0, 4'hF, 4'hA};
      for (int i = 0; i < 5; i++) begin
         drive(va[i], vb[i], ve[i], vc[i], vd[i], 1'b1);
         tick(); tick(); tick();
         checks++;
         if ({bus.out, bus.out_valid} !== {vexp[i], 1'b1}) begin
            errors++;
            $display("FAIL lane_vec%0d: got out=%h v=%b expected out=%h v=1",
                     i, bus.out, bus.out_valid, vexp[i]);
         end
      end
      idle();
      tick(); tick(); tick();
      pulse_clr();
   endtask

   task automatic test_trigger();
      idle();
      tick(); tick(); tick();
      pulse_clr();
      checks++;
      if ({bus.hit_cnt, bus.alarm} !== 9'h0) begin
         errors++;
         $display("FAIL trig_start: got cnt=%0d alarm=%b expected 0/0", bus.hit_cnt, bus.alarm);
      end
      for (int k = 1; k <= 4; k++) begin
         drive(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, (k <= 3) ? 1'b1 : 1'b0);
         tick();
         idle();
         tick(); tick();
         checks++;
         if ({bus.out, bus.out_valid} !== {4'hF, (k <= 3) ? 1'b1 : 1'b0}) begin
            errors++;
            $display("FAIL trig_out%0d: got out=%h v=%b expected out=f v=%b",
                     k, bus.out, bus.out_valid, (k <= 3) ? 1'b1 : 1'b0);
         end
         tick();
         checks++;
         if ({bus.hit_cnt, bus.alarm} !== {8'((k <= 3) ? k : 3), (k >= 3) ? 1'b1 : 1'b0}) begin
            errors++;
            $display("FAIL trig_cnt%0d: got cnt=%0d alarm=%b expected cnt=%0d alarm=%b",
                     k, bus.hit_cnt, bus.alarm, (k <= 3) ? k : 3, (k >= 3) ? 1'b1 : 1'b0);
         end
         tick();
      end
   endtask

   task automatic test_clear_vs_hit();
      drive(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
      tick();
      idle();
      tick(); tick();
      bus.clr = 1'b1;
      tick();
      bus.clr = 1'b0;
      checks++;
      if ({bus.hit_cnt, bus.alarm} !== 9'h0) begin
         errors++;
         $display("FAIL clr_vs_hit: got cnt=%0d alarm=%b expected 0/0", bus.hit_cnt, bus.alarm);
      end
      drive(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
      tick();
      idle();
      tick(); tick(); tick();
      checks++;
      if ({bus.hit_cnt, bus.alarm} !== {8'd1, 1'b0}) begin
         errors++;
         $display("FAIL clr_next_hit: got cnt=%0d alarm=%b expected 1/0", bus.hit_cnt, bus.alarm);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] sa [4];
      logic [3:0] sb [4];
      logic [3:0] se [4];
      logic       sv [4];
      logic [3:0] sexp [4];
      sa   = '{4'hF, 4'h5, 4'h0, 4'h6};
      sb   = '{4'h0, 4'h5, 4'h0, 4'h3};
      se   = '{4'h0, 4'h0, 4'h3, 4'h0};
      sv   = '{1'b1, 1'b0, 1'b1, 1'b1};
      sexp = '{4'hF, 4'hA, 4'hC, 4'hD};
      idle();
      tick(); tick(); tick();
      for (int i = 0; i < 6; i++) begin
         if (i < 4) drive(sa[i], sb[i], se[i], 4'h0, 4'h0, sv[i]);
         else       idle();
         tick();
         if (i >= 2) begin
            checks++;
            if ({bus.out, bus.out_valid} !== {sexp[i-2], sv[i-2]}) begin
               errors++;
               $display("FAIL b2b_%0d: got out=%h v=%b expected out=%h v=%b",
                        i - 2, bus.out, bus.out_valid, sexp[i-2], sv[i-2]);
            end
         end
      end
   endtask

   task automatic test_saturation();
      idle();
      tick(); tick(); tick();
      pulse_clr();
      for (int k = 1; k <= 5; k++) begin
         drive(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
         tick();
         idle();
         tick(); tick(); tick();
         checks++;
         if ({bus2.hit_cnt, bus.hit_cnt} !== {2'((k < 3) ? k : 3), 8'(k)}) begin
            errors++;
            $display("FAIL sat_hit%0d: got cnt2=%0d cnt8=%0d expected cnt2=%0d cnt8=%0d",
                     k, bus2.hit_cnt, bus.hit_cnt, (k < 3) ? k : 3, k);
         end
      end
      checks++;
      if ({bus2.alarm, bus.alarm} !== 2'b11) begin
         errors++;
         $display("FAIL sat_alarm: got alarm2=%b alarm8=%b expected 1/1", bus2.alarm, bus.alarm);
      end
   endtask

   task automatic test_reset_midstream();
      drive(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
      tick(); tick();
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({bus.out, bus.out_valid, bus.hit_cnt, bus.alarm, bus2.hit_cnt, bus2.alarm} !== 17'h0) begin
         errors++;
         $display("FAIL async_reset: got out=%h v=%b cnt=%0d alarm=%b cnt2=%0d alarm2=%b expected all 0",
                  bus.out, bus.out_valid, bus.hit_cnt, bus.alarm, bus2.hit_cnt, bus2.alarm);
      end
      idle();
      tick();
      rst = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         checks++;
         if ({bus.out_valid, bus.hit_cnt} !== 9'h0) begin
            errors++;
            $display("FAIL post_reset_flush%0d: got v=%b cnt=%0d expected v=0 cnt=0",
                     i, bus.out_valid, bus.hit_cnt);
         end
      end
      drive(4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
      for (int i = 1; i <= 3; i++) begin
         tick();
         checks++;
         if (bus.out_valid !== ((i == 3) ? 1'b1 : 1'b0)) begin
            errors++;
            $display("FAIL post_reset_valid%0d: got v=%b expected %b",
                     i, bus.out_valid, (i == 3) ? 1'b1 : 1'b0);
         end
      end
      checks++;
      if (bus.out !== 4'hF) begin
         errors++;
         $display("FAIL post_reset_out: got out=%h expected f", bus.out);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_latency();
      test_lane_logic();
      test_trigger();
      test_clear_vs_hit();
      test_back_to_back();
      test_saturation();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
